// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch/decode front end: datapath width, bubble word
// and the RV32I opcodes that decode and immediate generation dispatch on.
package if_id_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_OPIMM  = 7'd19;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_BRANCH = 7'd99;

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with its next-PC mux: redirect beats stall, else PC+4.
module pc_reg
    import if_id_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              PCSrc,
    input  logic [XLEN-1:2]   TargetWord,
    output logic [XLEN-1:0]   PC
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pcNext;

    // A redirect must not be lost to a stall, so PCSrc is tested first.
    always_comb begin
        w_pcNext = r_pc + 32'd4;
        if (PCSrc) begin
            w_pcNext = {TargetWord, 2'b00};
        end else if (Stall) begin
            w_pcNext = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pcNext;
        end
    end

    assign PC = r_pc;

endmodule

// File: rtl/if_id_stage.sv
// IF stage plus the IF/ID pipeline register, fetch counter and sticky
// misaligned-redirect flag.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_id_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Inst,
    output logic        IF_ID_Valid,
    output logic        MisalignErr,
    output logic [31:0] FetchCount
);

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] r_ifIdPc;
    logic [XLEN-1:0] r_ifIdInst;
    logic            r_ifIdValid;
    logic            r_misalignErr;
    logic [XLEN-1:0] r_fetchCount;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .PCSrc      (PCSrc),
        .TargetWord (BranchTarget[XLEN-1:2]),
        .PC         (w_pc)
    );

    // Flush overrides Stall; a redirect without Flush still captures normally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifIdPc     <= '0;
            r_ifIdInst   <= NOP_INST;
            r_ifIdValid  <= 1'b0;
            r_fetchCount <= '0;
        end else if (Flush) begin
            r_ifIdPc    <= '0;
            r_ifIdInst  <= NOP_INST;
            r_ifIdValid <= 1'b0;
        end else if (!Stall) begin
            r_ifIdPc     <= w_pc;
            r_ifIdInst   <= IMemData;
            r_ifIdValid  <= 1'b1;
            r_fetchCount <= r_fetchCount + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalignErr <= 1'b0;
        end else if (PCSrc && (BranchTarget[1:0] != 2'b00)) begin
            r_misalignErr <= 1'b1;
        end
    end

    assign IMemAddr    = w_pc;
    assign IF_ID_PC    = r_ifIdPc;
    assign IF_ID_Inst  = r_ifIdInst;
    assign IF_ID_Valid = r_ifIdValid;
    assign MisalignErr = r_misalignErr;
    assign FetchCount  = r_fetchCount;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomised bench for if_id_stage against a cycle-level reference model.
module tb_if_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Inst;
    logic        IF_ID_Valid;
    logic        MisalignErr;
    logic [31:0] FetchCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] mPc;
    logic [31:0] mIfIdPc;
    logic [31:0] mIfIdInst;
    logic        mValid;
    logic        mErr;
    logic [31:0] mCount;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign IMemData = memWord(IMemAddr);

    if_id_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .Flush        (Flush),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .IMemAddr     (IMemAddr),
        .IMemData     (IMemData),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_Inst   (IF_ID_Inst),
        .IF_ID_Valid  (IF_ID_Valid),
        .MisalignErr  (MisalignErr),
        .FetchCount   (FetchCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs held across it.
    task automatic modelStep();
        if (reset) begin
            mPc = RESET_PC; mIfIdPc = 0; mIfIdInst = NOP; mValid = 0;
            mErr = 0; mCount = 0;
        end else begin
            if (Flush) begin
                mIfIdPc = 0; mIfIdInst = NOP; mValid = 0;
            end else if (!Stall) begin
                mIfIdPc = mPc; mIfIdInst = memWord(mPc); mValid = 1;
                mCount = mCount + 1;
            end
            if (PCSrc && BranchTarget[1:0] != 2'b00) mErr = 1;
            if (PCSrc) mPc = BranchTarget & 32'hFFFF_FFFC;
            else if (!Stall) mPc = mPc + 4;
        end
    endtask

    task automatic checkAll();
        checkOutput("IMemAddr", IMemAddr, mPc);
        checkOutput("IF_ID_PC", IF_ID_PC, mIfIdPc);
        checkOutput("IF_ID_Inst", IF_ID_Inst, mIfIdInst);
        checkOutput("IF_ID_Valid", {31'b0, IF_ID_Valid}, {31'b0, mValid});
        checkOutput("MisalignErr", {31'b0, MisalignErr}, {31'b0, mErr});
        checkOutput("FetchCount", FetchCount, mCount);
    endtask

    task automatic applyStimulus(input logic rst, input logic stall, input logic flush,
                                 input logic pcsrc, input logic [31:0] target);
        reset = rst; Stall = stall; Flush = flush; PCSrc = pcsrc; BranchTarget = target;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        mPc = 0; mIfIdPc = 0; mIfIdInst = NOP; mValid = 0; mErr = 0; mCount = 0;
        reset = 1; Stall = 0; Flush = 0; PCSrc = 0; BranchTarget = 0;
        #2;

        // Reset state, then three free-running fetches.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 32'h0000_0203);
        checkOutput("rst_pc", IMemAddr, RESET_PC);
        checkOutput("rst_inst", IF_ID_Inst, NOP);
        checkOutput("rst_err", {31'b0, MisalignErr}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("first_inst", IF_ID_Inst, memWord(RESET_PC));
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("free3_addr", IMemAddr, 32'd12);
        checkOutput("free3_ifpc", IF_ID_PC, 32'd8);
        checkOutput("free3_cnt", FetchCount, 32'd3);

        // Two-cycle stall while PC=8.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("stall_addr", IMemAddr, 32'd8);
        checkOutput("stall_ifpc", IF_ID_PC, 32'd4);
        checkOutput("stall_cnt", FetchCount, 32'd2);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("resume_addr", IMemAddr, 32'd12);

        // Redirect + flush while stalled.
        applyStimulus(0, 1, 1, 1, 32'h0000_0040);
        checkOutput("rf_addr", IMemAddr, 32'h40);
        checkOutput("rf_valid", {31'b0, IF_ID_Valid}, 32'd0);
        checkOutput("rf_inst", IF_ID_Inst, 32'h0000_0013);

        // Misaligned redirect is sticky.
        applyStimulus(0, 0, 0, 1, 32'h0000_0102);
        checkOutput("mis_addr", IMemAddr, 32'h100);
        checkOutput("mis_err", {31'b0, MisalignErr}, 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mis_sticky", {31'b0, MisalignErr}, 32'd1);

        // PC wrap from the top of the address space.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrap_addr", IMemAddr, 32'd0);
        checkOutput("wrap_ifpc", IF_ID_PC, 32'hFFFF_FFFC);
        checkOutput("wrap_valid", {31'b0, IF_ID_Valid}, 32'd1);

        // Reset during a stall with five fetches counted.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("pre_cnt", FetchCount, 32'd5);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 32'h0000_0080);
        checkOutput("rs_pc", IMemAddr, RESET_PC);
        checkOutput("rs_cnt", FetchCount, 32'd0);
        checkOutput("rs_valid", {31'b0, IF_ID_Valid}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
            applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
